rc_add_sub_unit: RTL and testbench
==================================

# rc_add_sub_unit

32-bit ripple-carry adder/subtractor with registered outputs. Computes A+B or A−B (two's complement) through a chain of 32 full-adder cells. Captures sum and carry-out on the clock edge. Serves as the integer add/sub datapath element of the ALU.

## Interface
- Parameters: none. Width is fixed at 32 via the shared package constant `DATA_WIDTH = 32`.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `A`  in  32  operand 1, unsigned or two's-complement bit pattern.
- `B`  in  32  operand 2.
- `SnA`  in  1  operation select: 0 = add (A+B), 1 = subtract (A−B).
- `Y`  out  32  registered result, low 32 bits.
- `CO`  out  1  registered carry-out of bit 31.

## Operation
- Effective B operand: Bx[i] = B[i] XOR SnA for every bit.
- Carry-in to bit 0 = SnA. Subtract is therefore A + ~B + 1.
- Ripple chain, bit i = 0..31:
  - s[i] = A[i] ^ Bx[i] ^ c[i]
  - c[i+1] = A[i]&Bx[i] | c[i]&(A[i]^Bx[i])
- Y_next = s[31:0]. CO_next = c[32].
- Add: CO = 1 exactly when the unsigned sum is ≥ 2^32. Y wraps modulo 2^32.
- Subtract: CO = 1 exactly when A ≥ B unsigned (no borrow). CO = 0 on borrow, and Y holds the two's-complement wrap.
- No signed-overflow flag. Signed overflow is not reported: 0x7FFFFFFF+5 gives Y=0x80000004, CO=0.
- Operands are not latched separately. The combinational chain always sees the current A, B and SnA.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N appear on Y/CO after edge N.
- Throughput: one operation per cycle. No handshake; the block has no valid or ready signals.
- Reset: while RST_N = 0, Y = 32'h0 and CO = 0 immediately, independent of CLK.
- Reset deassertion: the first capture occurs on the first rising edge with RST_N = 1.
- Reset asserted mid-operation discards the in-flight result. Outputs clear asynchronously.
- SnA may change every cycle. The value sampled with A and B at the same edge governs that result.
- The combinational path is the full 32-stage ripple. The CLK period must exceed the worst-case carry propagation, for example 0xFFFFFFFF+1.

## Structure
- Shared package:
  - `DATA_WIDTH = 32`
  - operation encodings `OP_ADD = 1'b0`, `OP_SUB = 1'b1`
- Sub-module `full_adder`, 1-bit:
  - inputs a, b, ci; outputs s, co
  - instantiated 32 times via generate, carry chained bit 0 → 31.
- Top module:
  - XOR stage for B
  - generate chain
  - one output register, asynchronous clear, for Y and CO.

## Test plan
- Reset: assert RST_N=0 with A=5, B=2 → Y=0, CO=0 without any clock edge. Release, clock once → Y=7, CO=0.
- Add basics:
  - 0+0 → Y=0, CO=0
  - 5+2 → 7, CO=0
  - 2+5 → 7, CO=0
  - 100+1000 → 1100, CO=0
- Subtract basics:
  - 0−0 → Y=0, CO=1
  - 5−2 → 3, CO=1
  - 2−5 → 0xFFFFFFFD, CO=0
- Borrow/wrap:
  - 0x000000FF−0x0000FFFF → 0xFFFF0100, CO=0
  - 0x0−0x1 → 0xFFFFFFFF, CO=0
- Carry boundary:
  - 0x7FFFFFFF+5 → 0x80000004, CO=0
  - 0xFFFFFFFF+1 → 0x00000000, CO=1 (full ripple)
  - 0x80000000−0x80000000 → 0, CO=1
- Back-to-back: alternate SnA every cycle with A=5, B=2 → Y sequence 7, 3, 7, 3 with one-cycle latency. Random A/B/SnA compared against a {CO,Y} reference model.

Source files
------------

// File: rtl/rc_add_sub_unit_pkg.sv
// Shared constants for the ripple-carry add/sub datapath.
package rc_add_sub_unit_pkg;
  localparam int unsigned DATA_WIDTH = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/rc_add_sub_unit_full_adder.sv
// One-bit full adder cell; purely combinational, no state.
// Ripple-carry chains cascade these cells, so there is no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rc_add_sub_unit.sv
// 32-bit ripple-carry adder/subtractor. Latency is one cycle, set by the registered Y/CO.
// There is no handshake: the block accepts a new operation every cycle.
module rc_add_sub_unit
  import rc_add_sub_unit_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  SnA,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  CO
);

  logic [DATA_WIDTH-1:0] bx;
  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH:0]   c;
  logic [DATA_WIDTH-1:0] y_d, y_q;
  logic                  co_d, co_q;

  // Subtract is A + ~B + 1: SnA both inverts B and feeds the carry-in.
  assign bx   = B ^ {DATA_WIDTH{SnA == OP_SUB}};
  assign c[0] = (SnA == OP_SUB);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a  (A[i]),
      .b  (bx[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign y_d  = s;
  assign co_d = c[DATA_WIDTH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q  <= '0;
      co_q <= 1'b0;
    end else begin
      y_q  <= y_d;
      co_q <= co_d;
    end
  end

  assign Y  = y_q;
  assign CO = co_q;

endmodule

// File: tb/tb_rc_add_sub_unit.sv
// Directed and random checks of rc_add_sub_unit against a {CO,Y} scoreboard.
module tb_rc_add_sub_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] A, B;
  logic        SnA;
  logic [31:0] Y;
  logic        CO;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [32:0] val;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  rc_add_sub_unit dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .A     (A),
    .B     (B),
    .SnA   (SnA),
    .Y     (Y),
    .CO    (CO)
  );

  always #5 CLK = ~CLK;

  // Reference: add is a 33-bit sum; subtract uses the no-borrow definition of CO.
  function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    logic [32:0] r;
    if (op) begin
      r[31:0] = a - b;
      r[32]   = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed CO,Y=%h expected CO,Y=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [32:0] exp, input string tag);
    exp_t e;
    @(negedge CLK);
    A   = a;
    B   = b;
    SnA = op;
    e.val = exp;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed queue size=0 expected entry");
    end else begin
      e = sbq.pop_front();
      check(e.tag, {CO, Y}, e.val);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [32:0] exp, input string tag);
    drive(a, b, op, exp, tag);
    collect();
  endtask

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    logic        rop;

    // Reset clears outputs before any clock edge.
    RST_N = 1'b0;
    A     = 32'd5;
    B     = 32'd2;
    SnA   = 1'b0;
    #1;
    check("rst_async", {CO, Y}, 33'h0);
    #2;
    RST_N = 1'b1;
    e.val = {1'b0, 32'd7};
    e.tag = "rst_first_capture";
    sbq.push_back(e);
    collect();

    step(32'd0,   32'd0,    1'b0, {1'b0, 32'd0},    "add_0_0");
    step(32'd5,   32'd2,    1'b0, {1'b0, 32'd7},    "add_5_2");
    step(32'd2,   32'd5,    1'b0, {1'b0, 32'd7},    "add_2_5");
    step(32'd100, 32'd1000, 1'b0, {1'b0, 32'd1100}, "add_100_1000");

    step(32'd0, 32'd0, 1'b1, {1'b1, 32'd0},         "sub_0_0");
    step(32'd5, 32'd2, 1'b1, {1'b1, 32'd3},         "sub_5_2");
    step(32'd2, 32'd5, 1'b1, {1'b0, 32'hFFFFFFFD},  "sub_2_5");

    step(32'h000000FF, 32'h0000FFFF, 1'b1, {1'b0, 32'hFFFF0100}, "sub_ff_ffff");
    step(32'h0,        32'h1,        1'b1, {1'b0, 32'hFFFFFFFF}, "sub_0_1");

    step(32'h7FFFFFFF, 32'd5,        1'b0, {1'b0, 32'h80000004}, "add_sovf");
    step(32'hFFFFFFFF, 32'h1,        1'b0, {1'b1, 32'h00000000}, "add_full_ripple");
    step(32'h80000000, 32'h80000000, 1'b1, {1'b1, 32'h00000000}, "sub_msb_eq");

    // Back-to-back with SnA toggling each cycle.
    step(32'd5, 32'd2, 1'b0, {1'b0, 32'd7}, "b2b_0");
    step(32'd5, 32'd2, 1'b1, {1'b1, 32'd3}, "b2b_1");
    step(32'd5, 32'd2, 1'b0, {1'b0, 32'd7}, "b2b_2");
    step(32'd5, 32'd2, 1'b1, {1'b1, 32'd3}, "b2b_3");

    // Reset mid-operation: in-flight result is discarded, outputs clear at once.
    @(negedge CLK);
    A     = 32'd9;
    B     = 32'd9;
    SnA   = 1'b0;
    RST_N = 1'b0;
    #1;
    check("rst_mid_async", {CO, Y}, 33'h0);
    @(posedge CLK);
    #1;
    check("rst_mid_held", {CO, Y}, 33'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    step(32'd9, 32'd9, 1'b0, {1'b0, 32'd18}, "post_rst_add");

    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      step(ra, rb, rop, ref_model(ra, rb, rop), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    total++;
    bad++;
    $display("FAIL timeout observed time limit reached expected test completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
